ev_retire_stage: RTL and testbench
==================================

Name: ev_retire_stage

Overview:
- Pipeline stage directly downstream of the execution function units (differenceMap_f and siblings).
- Accepts one executed ex_ev_t per handshake, together with the bit length of the instruction just executed.
- Retires that instruction by shifting it out of thread.opcodes, so the next opcode sits at opcodes[0]. Presents the event to the next dispatch stage through a registered valid/ready interface with a 2-entry skid buffer.
- Keeps a global retired-instruction count, a per-event done flag and a sticky shift-error flag.

Parameters:
- OPC_W, $bits(test.thread.opcodes) of ex_ev_t: opcode field width in bits.
- SHIFT_W, $clog2(OPC_W+1): width of in_shift.
- COUNT_W, 32: width of retired_count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream event valid.
- in_ready  out  1  stage can accept; registered.
- in_ev  in  $bits(ex_ev_t)  executed event (function-unit result).
- in_shift  in  SHIFT_W  opcode bits used by the executed instruction, e.g. $bits(differenceMap_a).
- out_valid  out  1  output event valid.
- out_ready  in  1  downstream accepts.
- out_ev  out  $bits(ex_ev_t)  event with the retired opcode removed.
- out_done  out  1  out_ev.thread.opcodes is all zero (program finished); qualified by out_valid.
- retired_count  out  COUNT_W  number of events accepted since reset.
- shift_err  out  1  sticky; set when an accepted in_shift > OPC_W.

Behaviour:
- Reset (async assert, sync release):
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - out_valid=0, out_done=0, out_ev=0, retired_count=0, shift_err=0, skid buffer empty.
- Transform, applied on accept (in_valid & in_ready):
  - All fields other than thread.opcodes pass through unchanged. This includes thread.u32 words that overlap opcodes, which are affected only through the opcodes view.
  - new.opcodes[i] = old.opcodes[i+s] for i+s < OPC_W, else 0, where s = min(in_shift, OPC_W). opcodes is indexed ascending; index 0 is the first opcode bit.
  - in_shift=0: opcodes unchanged (legal, no-op retire).
  - in_shift>OPC_W: treated as OPC_W (opcodes become all zero) and shift_err is set.
  - done = (new.opcodes == 0).
- Storage: main register M (drives out_*) and skid register S, each holding {ev, done, valid}.
- Latency: accepted event appears on out_ev in the next cycle when M is empty or draining.
- Per-cycle update, with acc = in_valid&in_ready and drn = out_valid&out_ready:
  - M empty, or drn: M <= S if S is valid, else the transformed input if acc, else empty. When S moves into M and acc is also true, S <= transformed input; otherwise S <= empty.
  - M full and no drn: if acc, S <= transformed input.
  - in_ready (registered) = !S.valid after the update.
  - No event is ever dropped or duplicated; order is strictly FIFO.
- out_valid/out_ev/out_done must stay stable while out_valid & !out_ready.
- Throughput: 1 event/cycle while out_ready stays high.
- retired_count increments by 1 on every accept and wraps modulo 2^COUNT_W. It counts accepted events, not drained ones.
- shift_err clears only on rst.
- Simultaneous accept and drain with S empty: M is replaced by the new event in the same edge; no bubble.
- rst asserted mid-transfer: all held events are discarded immediately (asynchronous) and outputs return to reset values.

Test Plan:
1. Single event, opcodes[0:15]=16'hABCD with remaining bits 0, in_shift=8, out_ready=1.
   - Next cycle: out_valid=1, out_ev.opcodes[0:7]=8'hCD, all later bits 0, out_done=0.
   - data/shared/thread.u32 bit-identical to input; retired_count=1.
2. Back-pressure.
   - Stream 4 events (data.u32[0]=1..4) with out_ready=0: in_ready falls after 2 accepts and out_ev holds event 1 stable.
   - Raise out_ready: events drain 1,2,3,4 in order, one per cycle; retired_count=4.
3. Done/overflow.
   - Opcodes nonzero only in first 8 bits, in_shift=8: out_done=1, shift_err=0.
   - Then in_shift=OPC_W+1: opcodes all zero, out_done=1, shift_err=1 and staying 1 until rst.
4. in_shift=0 with opcodes=random R: out_ev.opcodes==R, out_done=(R==0).
5. Full-rate stream of 100 events with random out_ready (50%).
   - Scoreboard: every output equals the model transform, in order, with none lost.
   - out_ev never changes while out_valid&!out_ready.
6. Reset mid-operation: with M and S both full, assert rst asynchronously between edges.
   - out_valid drops to 0 immediately and retired_count reads 0.
   - After release, the first new event passes with latency 1.

Source files
------------

// File: rtl/ev_retire_stage.sv
// Retire stage: strips the just-executed instruction's bits off the front of thread.opcodes
// and hands the event downstream through a registered valid/ready port with a 2-entry skid.
module ev_retire_stage #(
    parameter int unsigned OPC_W   = 64,
    parameter int unsigned SHIFT_W = $clog2(OPC_W + 1),
    parameter int unsigned COUNT_W = 32,
    parameter int unsigned EV_W    = 160,
    parameter int unsigned OPC_LSB = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EV_W-1:0]    in_ev,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EV_W-1:0]    out_ev,
    output logic               out_done,
    output logic [COUNT_W-1:0] retired_count,
    output logic               shift_err
);

    logic [EV_W-1:0]    m_ev_q, m_ev_d, s_ev_q, s_ev_d;
    logic               m_done_q, m_done_d, s_done_q, s_done_d;
    logic               m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;

    logic               acc, drn, over;
    logic [SHIFT_W-1:0] s_sat;
    logic [OPC_W-1:0]   opc_old, opc_new;
    logic [EV_W-1:0]    x_ev;
    logic               x_done;

    // Opcode index 0 is the field MSB, so retiring bits is a left shift of the field.
    always_comb begin
        over    = in_shift > SHIFT_W'(OPC_W);
        s_sat   = over ? SHIFT_W'(OPC_W) : in_shift;
        opc_old = in_ev[OPC_LSB +: OPC_W];
        opc_new = (s_sat >= SHIFT_W'(OPC_W)) ? '0 : (opc_old << s_sat);
        x_ev    = in_ev;
        x_ev[OPC_LSB +: OPC_W] = opc_new;
        x_done  = (opc_new == '0);
    end

    always_comb begin
        acc       = in_valid & in_ready_q;
        drn       = m_valid_q & out_ready;
        m_ev_d    = m_ev_q;
        m_done_d  = m_done_q;
        m_valid_d = m_valid_q;
        s_ev_d    = s_ev_q;
        s_done_d  = s_done_q;
        s_valid_d = s_valid_q;
        count_d   = acc ? count_q + COUNT_W'(1) : count_q;
        err_d     = err_q | (acc & over);

        if (!m_valid_q || drn) begin
            if (s_valid_q) begin
                m_ev_d    = s_ev_q;
                m_done_d  = s_done_q;
                m_valid_d = 1'b1;
                if (acc) begin
                    s_ev_d   = x_ev;
                    s_done_d = x_done;
                end else begin
                    s_valid_d = 1'b0;
                end
            end else if (acc) begin
                m_ev_d    = x_ev;
                m_done_d  = x_done;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = 1'b0;
                s_valid_d = 1'b0;
            end
        end else if (acc) begin
            // M is stalled; in_ready guarantees S is free here.
            s_ev_d    = x_ev;
            s_done_d  = x_done;
            s_valid_d = 1'b1;
        end

        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ev_q     <= '0;
            m_done_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            s_ev_q     <= '0;
            s_done_q   <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            m_ev_q     <= m_ev_d;
            m_done_q   <= m_done_d;
            m_valid_q  <= m_valid_d;
            s_ev_q     <= s_ev_d;
            s_done_q   <= s_done_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = m_valid_q;
    assign out_ev        = m_ev_q;
    assign out_done      = m_done_q & m_valid_q;
    assign retired_count = count_q;
    assign shift_err     = err_q;

endmodule

// File: tb/tb_ev_retire_stage.sv
// Bench for ev_retire_stage: directed vector table, back-pressure, random stream vs. model, reset.
module tb_ev_retire_stage;

    localparam int unsigned OPC_W   = 64;
    localparam int unsigned SHIFT_W = $clog2(OPC_W + 1);
    localparam int unsigned COUNT_W = 32;
    localparam int unsigned EV_W    = 160;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [EV_W-1:0]    in_ev = '0;
    logic [SHIFT_W-1:0] in_shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [EV_W-1:0]    out_ev;
    logic               out_done;
    logic [COUNT_W-1:0] retired_count;
    logic               shift_err;

    ev_retire_stage #(
        .OPC_W  (OPC_W),
        .SHIFT_W(SHIFT_W),
        .COUNT_W(COUNT_W),
        .EV_W   (EV_W),
        .OPC_LSB(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ev        (in_ev),
        .in_shift     (in_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ev       (out_ev),
        .out_done     (out_done),
        .retired_count(retired_count),
        .shift_err    (shift_err)
    );

    always #5 clk = ~clk;

    // Event layout: {data.u32[1], data.u32[0], shared, thread.opcodes[0:63]}.
    typedef struct {
        logic [63:0] opc;
        int          shift;
        logic [63:0] exp_opc;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [EV_W-1:0] ev;
        int              shift;
    } stim_t;

    typedef struct {
        logic [EV_W-1:0] ev;
        logic            done;
    } resp_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    int    acc_total = 0;
    bit    rand_rdy = 1'b0;
    vec_t  tbl[9];
    stim_t pend_q[$];
    resp_t exp_q[$];

    task automatic chk(input string name, input logic [EV_W-1:0] act, input logic [EV_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: opcode i of the result is opcode i+s of the source, zero past the end.
    function automatic resp_t model(input logic [EV_W-1:0] ev, input int sh);
        logic [0:OPC_W-1] o, n;
        int s;
        resp_t r;
        s = (sh > OPC_W) ? OPC_W : sh;
        o = ev[OPC_W-1:0];
        for (int i = 0; i < OPC_W; i++) n[i] = (i + s < OPC_W) ? o[i+s] : 1'b0;
        r.ev = ev;
        r.ev[OPC_W-1:0] = n;
        r.done = (n == '0);
        return r;
    endfunction

    function automatic logic [EV_W-1:0] mk_ev(input logic [31:0] d0, input logic [63:0] opc);
        return {$urandom(), d0, $urandom(), opc};
    endfunction

    // One clock of streaming: drive from pend_q, predict on accept, compare on drain.
    task automatic tick();
        bit fire_in, fire_out, stall;
        logic [EV_W-1:0] held;
        resp_t e;
        if (rand_rdy) out_ready = $urandom_range(0, 1) == 1;
        if (pend_q.size() > 0) begin
            in_valid = 1'b1;
            in_ev    = pend_q[0].ev;
            in_shift = SHIFT_W'(pend_q[0].shift);
        end else begin
            in_valid = 1'b0;
        end
        fire_in  = in_valid & in_ready;
        fire_out = out_valid & out_ready;
        stall    = out_valid & !out_ready;
        held     = out_ev;
        if (fire_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_ev, '0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_ev", out_ev, e.ev);
                chk("stream_done", out_done, e.done);
            end
        end
        @(posedge clk);
        #1;
        if (fire_in) begin
            exp_q.push_back(model(pend_q[0].ev, pend_q[0].shift));
            void'(pend_q.pop_front());
            acc_total++;
        end
        if (stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_ev", out_ev, held);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        resp_t e;
        stim_t st;
        int guard;

        tbl[0] = '{64'hABCD_0000_0000_0000, 8,  64'hCD00_0000_0000_0000, 1'b0, 1'b0};
        tbl[1] = '{64'hFF00_0000_0000_0000, 8,  64'h0,                   1'b1, 1'b0};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 0,  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        tbl[3] = '{64'h0,                   0,  64'h0,                   1'b1, 1'b0};
        tbl[4] = '{64'h0123_4567_89AB_CDEF, 4,  64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
        tbl[5] = '{64'h0000_0000_0000_0001, 63, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h0,                   1'b1, 1'b0};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 65, 64'h0,                   1'b1, 1'b1};
        tbl[8] = '{64'hDEAD_BEEF_0000_0001, 0,  64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1};

        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_done", out_done, 1'b0);
        chk("rst_out_ev", out_ev, '0);
        chk("rst_count", retired_count, '0);
        chk("rst_err", shift_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // Directed single-event vectors, each accepted and observed one cycle later.
        out_ready = 1'b1;
        foreach (tbl[k]) begin
            in_ev    = mk_ev($urandom(), tbl[k].opc);
            in_shift = SHIFT_W'(tbl[k].shift);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_total++;
            chk($sformatf("vec%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("vec%0d_opc", k), out_ev[63:0], tbl[k].exp_opc);
            chk($sformatf("vec%0d_pass", k), out_ev[EV_W-1:64], in_ev[EV_W-1:64]);
            chk($sformatf("vec%0d_done", k), out_done, tbl[k].exp_done);
            chk($sformatf("vec%0d_err", k), shift_err, tbl[k].exp_err);
            chk($sformatf("vec%0d_count", k), retired_count, COUNT_W'(acc_total));
        end

        // Zero-length retire of a random opcode field.
        r        = {$urandom(), $urandom()};
        in_ev    = mk_ev(32'h0, r);
        in_shift = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_total++;
        chk("noop_opc", out_ev[63:0], r);
        chk("noop_done", out_done, r == 64'h0);
        @(posedge clk);
        #1;
        chk("drained_idle", out_valid, 1'b0);

        // Back-pressure: 4 events into a stalled output.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            st.ev    = mk_ev(32'(k), {$urandom(), $urandom()});
            st.shift = $urandom_range(0, OPC_W);
            pend_q.push_back(st);
        end
        for (int c = 0; c < 5; c++) tick();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_head", out_ev[127:96], 32'd1);
        chk("bp_accepts", pend_q.size(), 2);
        out_ready = 1'b1;
        guard = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && guard < 20) begin
            tick();
            guard++;
        end
        chk("bp_drain_timeout", guard < 20, 1'b1);
        chk("bp_count", retired_count, COUNT_W'(acc_total));

        // Random full-rate stream with random back-pressure.
        for (int k = 0; k < 100; k++) begin
            st.ev    = mk_ev($urandom(), ($urandom_range(0, 3) == 0) ? 64'h0 :
                                          {$urandom(), $urandom()});
            st.shift = $urandom_range(0, OPC_W + 2);
            pend_q.push_back(st);
        end
        rand_rdy = 1'b1;
        guard = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
            tick();
            guard++;
        end
        rand_rdy = 1'b0;
        chk("rand_timeout", guard < 2000, 1'b1);
        chk("rand_lost", exp_q.size(), 0);
        chk("rand_count", retired_count, COUNT_W'(acc_total));
        chk("err_sticky", shift_err, 1'b1);

        // Reset while both entries hold events.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st.ev    = mk_ev(32'(k), 64'hFFFF_0000_0000_0000);
            st.shift = 4;
            pend_q.push_back(st);
        end
        guard = 0;
        while (in_ready && guard < 10) begin
            tick();
            guard++;
        end
        chk("fill_timeout", guard < 10, 1'b1);
        chk("fill_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_count", retired_count, '0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_err", shift_err, 1'b0);
        chk("arst_out_ev", out_ev, '0);
        pend_q.delete();
        exp_q.delete();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel2_in_ready", in_ready, 1'b1);
        in_ev     = mk_ev(32'h55, 64'h1234_0000_0000_0000);
        in_shift  = SHIFT_W'(12);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        e = model(in_ev, 12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_ev", out_ev, e.ev);
        chk("post_rst_opc", out_ev[63:0], 64'h4000_0000_0000_0000);
        chk("post_rst_count", retired_count, COUNT_W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
